// File: rtl/mux_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_bus_arbiter_if
//  Purpose  : Request/grant and mux-control bundle shared between the
//             round-robin arbiter and the requesters / mux_8x1 it controls.
//  Revision : 1.0  initial release
// ============================================================================
interface mux_bus_arbiter_if;

   logic [7:0] req;      // req[i] high = requester i wants the bus
   logic [7:0] gnt;      // one-hot grant, zero when the bus is unowned
   logic [2:0] select;   // mux select, index of current/last owner
   logic       en;       // mux enable, high only while a grant is live
   logic       preempt;  // single-cycle pulse on hold-timeout revocation
   logic       busy;     // arbiter is in a grant or turnaround cycle

   // Arbiter side: consumes requests, drives grant and mux control
   modport master (
      input  req,
      output gnt,
      output select,
      output en,
      output preempt,
      output busy
   );

   // Requester / mux side: drives requests, observes grant and mux control
   modport slave (
      output req,
      input  gnt,
      input  select,
      input  en,
      input  preempt,
      input  busy
   );

endinterface
`default_nettype wire

// File: rtl/mux_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_bus_arbiter
//  Purpose  : Round-robin arbiter sharing one 8-input mux bus among eight
//             requesters. Drives mux select/enable directly, inserts a
//             one-cycle turnaround with enable low between owners, and
//             revokes a grant after MAX_HOLD cycles when others are waiting.
//  Revision : 1.0  initial release
// ============================================================================
module mux_bus_arbiter #(
   parameter int MAX_HOLD = 16,               // legal range 2..256
   parameter int CW       = $clog2(MAX_HOLD)  // derived, do not override
) (
   input  wire                 clk,
   input  wire                 rst_n,
   mux_bus_arbiter_if.master   bus
);

   // Saturation value of the hold counter; reaching it arms preemption.
   localparam logic [CW-1:0] c_hold_max = CW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_TURN  = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   state_t          r_state;
   logic [7:0]      r_gnt;
   logic [2:0]      r_select;
   logic            r_en;
   logic            r_preempt;
   logic [2:0]      r_last;     // round-robin pointer: most recent owner
   logic [CW-1:0]   r_hold;     // granted cycles elapsed for current owner

   // ------------------------------------------------------------------------
   // Next-state values
   // ------------------------------------------------------------------------
   state_t          w_state;
   logic [7:0]      w_gnt;
   logic [2:0]      w_select;
   logic            w_en;
   logic            w_preempt;
   logic [2:0]      w_last;
   logic [CW-1:0]   w_hold;

   // Arbitration helpers
   logic [2:0]      w_winner;
   logic            w_any_req;
   logic            w_owner_req;
   logic            w_others_req;
   logic [7:0]      w_owner_mask;

   // First requester found scanning last+1, last+2, ... wrapping back to last.
   // The previous owner is therefore reached only after every other index.
   function automatic logic [2:0] f_winner(input logic [7:0] req,
                                           input logic [2:0] last);
      logic [2:0] idx;
      logic       found;
      f_winner = last;
      found    = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         idx = last + 3'(k);
         if (!found && req[idx]) begin
            f_winner = idx;
            found    = 1'b1;
         end
      end
   endfunction

   // Request decode relative to the round-robin pointer and current owner
   always_comb begin
      w_winner     = f_winner(bus.req, r_last);
      w_any_req    = |bus.req;
      w_owner_mask = 8'b1 << r_select;
      w_owner_req  = |(bus.req & w_owner_mask);
      w_others_req = |(bus.req & ~w_owner_mask);
   end

   // Next-state and next-output computation for the IDLE/GRANT/TURN machine
   always_comb begin
      w_state   = r_state;
      w_gnt     = r_gnt;
      w_select  = r_select;
      w_en      = r_en;
      w_preempt = 1'b0;
      w_last    = r_last;
      w_hold    = r_hold;

      case (r_state)
         // IDLE and TURN arbitrate identically; TURN sees the pointer
         // already advanced past the owner that just left.
         S_IDLE, S_TURN: begin
            if (w_any_req) begin
               w_state  = S_GRANT;
               w_gnt    = 8'b1 << w_winner;
               w_select = w_winner;
               w_en     = 1'b1;
               w_hold   = '0;
            end else begin
               w_state  = S_IDLE;
               w_gnt    = '0;
               w_en     = 1'b0;
            end
         end

         S_GRANT: begin
            if (!w_owner_req) begin
               // Voluntary release wins over a coincident timeout.
               w_state = S_TURN;
               w_gnt   = '0;
               w_en    = 1'b0;
               w_last  = r_select;
            end else if ((r_hold == c_hold_max) && w_others_req) begin
               // Owner has had MAX_HOLD cycles and someone else is waiting.
               w_state   = S_TURN;
               w_gnt     = '0;
               w_en      = 1'b0;
               w_last    = r_select;
               w_preempt = 1'b1;
            end else if (r_hold != c_hold_max) begin
               // Saturate so a lone owner can keep the bus indefinitely.
               w_hold = r_hold + 1'b1;
            end
         end

         default: begin
            w_state = S_IDLE;
            w_gnt   = '0;
            w_en    = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_select  <= '0;
         r_en      <= 1'b0;
         r_preempt <= 1'b0;
         r_last    <= 3'd7;
         r_hold    <= '0;
      end else begin
         r_state   <= w_state;
         r_gnt     <= w_gnt;
         r_select  <= w_select;
         r_en      <= w_en;
         r_preempt <= w_preempt;
         r_last    <= w_last;
         r_hold    <= w_hold;
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.select  = r_select;
   assign bus.en      = r_en;
   assign bus.preempt = r_preempt;
   assign bus.busy    = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/mux_bus_arbiter.md
Name: mux_bus_arbiter

Overview:
- Round-robin arbiter that shares one 8-input mux_8x1 bus between 8 requesters.
- Drives the mux `select` and `en` directly.
- Inserts a one-cycle turnaround with `en` low between owners, so the tri-stated mux output is never switched while driven.
- Enforces a maximum hold time so no requester can starve the others.

Parameters:
MAX_HOLD, 16, max consecutive granted cycles before preemption when others are waiting; legal range 2..256
CW, $clog2(MAX_HOLD), width of the internal hold counter (derived; do not override)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
req  input  8  request vector, req[i] high = requester i wants the bus; held high for the full transfer
gnt  output  8  one-hot grant, registered; all-zero when the bus is unowned
select  output  3  registered index of current/last owner; drives mux select
en  output  1  registered mux enable; high only in GRANT state
preempt  output  1  one-cycle pulse when the owner's grant is revoked by hold timeout
busy  output  1  high in GRANT and TURN states

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; gnt=0; select=0; en=0; preempt=0; busy=0; hold counter=0.
  - Round-robin pointer last=7, so req[0] has top priority first.
  - Reset overrides every state, including mid-grant; outputs take reset values on that same edge.
- Winner function: first i with req[i]=1, searching (last+1) mod 8, (last+2) mod 8, ..., last, in that order.
- States IDLE, GRANT, TURN:
  - IDLE:
    - busy=0, en=0, gnt=0.
    - If req!=0 at an edge → GRANT with owner=winner.
    - gnt[owner]=1, select=owner, en=1, hold counter=0, all registered on that edge.
    - Latency req→gnt is exactly 1 cycle.
  - GRANT:
    - Each edge, the hold counter increments and saturates at MAX_HOLD-1.
    - Release: if req[owner]=0 at an edge → TURN; gnt=0, en=0, last=owner, select unchanged.
    - Preemption: if req[owner]=1, counter==MAX_HOLD-1 and (req & ~(1<<owner))!=0 → TURN, same updates as release, plus preempt=1 for exactly that one cycle.
    - If the counter is saturated and no other request is pending, the owner keeps the bus indefinitely. Preemption fires on the first edge where another request is present.
    - If the owner drops req on the same edge a timeout would fire, treat it as a release; preempt stays 0.
    - The owner receives exactly MAX_HOLD granted cycles before a preemption takes effect.
  - TURN:
    - Exactly one cycle: en=0, gnt=0, busy=1.
    - Arbitration uses the updated last. If req!=0 → GRANT with new winner (same updates as IDLE); else → IDLE, busy=0.
    - The previous owner may win again only if it is the sole requester.
- Invariants, checked every cycle:
  - gnt is one-hot or zero.
  - en==|gnt.
  - When en=1, select equals the index of the set gnt bit.
  - preempt is never high two consecutive cycles.
- A requester that drops req before being granted is simply not selected; no state is retained for it.
- Minimum spacing between two different owners is 1 idle-bus cycle (TURN).

Test Plan:
- Reset then req=8'h01 → next cycle gnt=8'h01, select=0, en=1; drop req → next cycle en=0, busy=1 (TURN); following cycle busy=0 (IDLE).
- Reset, req=8'hFF held, each owner drops its req after 3 granted cycles then reasserts → grant order 0,1,2,...,7,0. Each grant is 3 cycles wide with one en=0 cycle between.
- MAX_HOLD=4: req[2] held, req[5] asserted 1 cycle later → gnt[2] lasts exactly 4 cycles, preempt=1 on the TURN cycle, then gnt=8'h20, select=5.
- MAX_HOLD=4: req[3] alone for 10 cycles → gnt stays 8'h08 with preempt=0. Assert req[6] at cycle 10 → TURN on the next edge with preempt=1, then gnt=8'h40.
- Owner drops req on the exact timeout edge while another requester waits → TURN with preempt=0, next owner granted.
- rst_n low for 1 cycle mid-GRANT (gnt=8'h10) → gnt=0, en=0, select=0, busy=0 on that edge. With req=8'h90 afterwards, req[4] wins (pointer reset to 7).
